// File: rtl/arb_pkg.sv
// Shared constants, state encoding and grant decode helper for the 8-way arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Binary owner index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick_next.sv
// Rotating-priority search: first set request bit at ptr, ptr+1, ... ptr+7 (mod 8).
// Latency: purely combinational.
// Backpressure: none; result is only consumed by the arbiter FSM while idle.
module rr_pick_next
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin 8-way arbiter holding a one-hot grant until done, request drop or hold limit.
// Latency: request to grant one cycle; release to next grant adds one idle turnaround cycle.
// Backpressure: owner keeps the resource while req stays high; MAX_HOLD caps tenure.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   grant_idx_nxt;
  logic               grant_valid_nxt;
  logic               timeout_nxt;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               rel_done, rel_drop, rel_max;

  rr_pick_next u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Release causes; only acted on while a grant is held.
  assign rel_done = done;
  assign rel_drop = ~req[grant_idx];
  assign rel_max  = (hold_cnt == HOLD_LAST);

  // Next-state and next-output logic; everything lands in registers.
  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    hold_cnt_nxt    = hold_cnt;
    grant_nxt       = grant;
    grant_idx_nxt   = grant_idx;
    grant_valid_nxt = grant_valid;
    timeout_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt       = ST_GRANT;
          grant_nxt       = idx2onehot(pick_idx);
          grant_idx_nxt   = pick_idx;
          grant_valid_nxt = 1'b1;
          hold_cnt_nxt    = '0;
        end
      end
      ST_GRANT: begin
        hold_cnt_nxt = hold_cnt + 1'b1;
        if (rel_done || rel_drop || rel_max) begin
          state_nxt       = ST_IDLE;
          grant_nxt       = '0;
          grant_valid_nxt = 1'b0;
          hold_cnt_nxt    = '0;
          // Owner index stays put; it is don't-care while grant_valid is low.
          ptr_nxt         = grant_idx + 1'b1;
          // Flag a forced release only when the owner gave no sign of finishing.
          timeout_nxt     = rel_max && !rel_done && !rel_drop;
        end
      end
      default: begin
        state_nxt       = ST_IDLE;
        grant_nxt       = '0;
        grant_valid_nxt = 1'b0;
        hold_cnt_nxt    = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_cnt_nxt;
      grant       <= grant_nxt;
      grant_idx   <= grant_idx_nxt;
      grant_valid <= grant_valid_nxt;
      timeout     <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: reset, single grant, fairness, wrap, timeout,
// request drop and asynchronous reset. Inputs change and outputs are sampled on negedge.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // {valid, idx, grant, timeout} when owned; {valid, grant, timeout} when idle.
  logic [12:0] obs;
  logic [9:0]  obs_idle;
  assign obs      = {grant_valid, grant_idx, grant, timeout};
  assign obs_idle = {grant_valid, grant, timeout};

  rr_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 13'b0) begin
      failures++;
      $display("FAIL reset_state: v/idx/grant/to=%b/%0d/%b/%b required 0/0/00000000/0",
               grant_valid, grant_idx, grant, timeout);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 13'b0) begin
      failures++;
      $display("FAIL idle_no_req: v/idx/grant/to=%b/%0d/%b/%b required 0/0/00000000/0",
               grant_valid, grant_idx, grant, timeout);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'b0000_0100;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd2, 8'b0000_0100, 1'b0}) begin
      failures++;
      $display("FAIL single_grant: v/idx/grant/to=%b/%0d/%b/%b required 1/2/00000100/0",
               grant_valid, grant_idx, grant, timeout);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (obs_idle !== 10'b0) begin
      failures++;
      $display("FAIL single_release: v/grant/to=%b/%b/%b required 0/00000000/0",
               grant_valid, grant, timeout);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_g;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'b1 << (k % 8);
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 3'(k % 8), exp_g, 1'b0}) begin
        failures++;
        $display("FAIL fair_grant_%0d: v/idx/grant=%b/%0d/%b required 1/%0d/%b",
                 k, grant_valid, grant_idx, grant, k % 8, exp_g);
      end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      checks++;
      if (obs_idle !== 10'b0) begin
        failures++;
        $display("FAIL fair_gap_%0d: v/grant/to=%b/%b/%b required 0/00000000/0",
                 k, grant_valid, grant, timeout);
      end
    end
    req = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'b0100_0000;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd6, 8'b0100_0000, 1'b0}) begin
      failures++;
      $display("FAIL wrap_owner6: v/idx/grant=%b/%0d/%b required 1/6/01000000",
               grant_valid, grant_idx, grant);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 8'b1000_0001;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd7, 8'b1000_0000, 1'b0}) begin
      failures++;
      $display("FAIL wrap_owner7: v/idx/grant=%b/%0d/%b required 1/7/10000000",
               grant_valid, grant_idx, grant);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd0, 8'b0000_0001, 1'b0}) begin
      failures++;
      $display("FAIL wrap_owner0: v/idx/grant=%b/%0d/%b required 1/0/00000001",
               grant_valid, grant_idx, grant);
    end
    req = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'b0000_1000;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 3'd3, 8'b0000_1000, 1'b0}) begin
        failures++;
        $display("FAIL hold_cycle_%0d: v/idx/grant/to=%b/%0d/%b/%b required 1/3/00001000/0",
                 c, grant_valid, grant_idx, grant, timeout);
      end
    end
    @(negedge clk);
    checks++;
    if (obs_idle !== {1'b0, 8'b0, 1'b1}) begin
      failures++;
      $display("FAIL timeout_pulse: v/grant/to=%b/%b/%b required 0/00000000/1",
               grant_valid, grant, timeout);
    end
    // req[3] still high: regranted after the turnaround, pulse gone.
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd3, 8'b0000_1000, 1'b0}) begin
      failures++;
      $display("FAIL timeout_regrant: v/idx/grant/to=%b/%0d/%b/%b required 1/3/00001000/0",
               grant_valid, grant_idx, grant, timeout);
    end
    repeat (15) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (obs_idle !== 10'b0) begin
      failures++;
      $display("FAIL timeout_suppressed: v/grant/to=%b/%b/%b required 0/00000000/0",
               grant_valid, grant, timeout);
    end
    req = '0;
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 8'b0010_0000;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd5, 8'b0010_0000, 1'b0}) begin
      failures++;
      $display("FAIL drop_owner5: v/idx/grant=%b/%0d/%b required 1/5/00100000",
               grant_valid, grant_idx, grant);
    end
    // Other requesters arriving mid-grant must not disturb the owner.
    req = 8'b1110_0000;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd5, 8'b0010_0000, 1'b0}) begin
      failures++;
      $display("FAIL drop_others_ignored: v/idx/grant=%b/%0d/%b required 1/5/00100000",
               grant_valid, grant_idx, grant);
    end
    req = 8'b0100_0001;
    @(negedge clk);
    checks++;
    if (obs_idle !== 10'b0) begin
      failures++;
      $display("FAIL drop_release: v/grant/to=%b/%b/%b required 0/00000000/0",
               grant_valid, grant, timeout);
    end
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd6, 8'b0100_0000, 1'b0}) begin
      failures++;
      $display("FAIL drop_ptr6: v/idx/grant=%b/%0d/%b required 1/6/01000000",
               grant_valid, grant_idx, grant);
    end
    req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'b0001_0000;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 8'b0000_0010;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd1, 8'b0000_0010, 1'b0}) begin
      failures++;
      $display("FAIL areset_owner1: v/idx/grant=%b/%0d/%b required 1/1/00000010",
               grant_valid, grant_idx, grant);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_idle !== 10'b0) begin
      failures++;
      $display("FAIL areset_immediate: v/grant/to=%b/%b/%b required 0/00000000/0",
               grant_valid, grant, timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 8'b0010_0001;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd0, 8'b0000_0001, 1'b0}) begin
      failures++;
      $display("FAIL areset_ptr0: v/idx/grant=%b/%0d/%b required 1/0/00000001",
               grant_valid, grant_idx, grant);
    end
    do_reset();
    req = 8'b1000_0000;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd7, 8'b1000_0000, 1'b0}) begin
      failures++;
      $display("FAIL areset_owner7: v/idx/grant=%b/%0d/%b required 1/7/10000000",
               grant_valid, grant_idx, grant);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_req_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
